pt_mapper: RTL and testbench
============================

PT_MAPPER -- requirements
Module: pt_mapper

Interface
REQ-001 Parameter ROOT_BASE, default 32'h0000_0010: byte address of the Sv32 root (level-1) page table.
REQ-002 Parameter FREE_BASE, default 32'h0001_0000: first 4 KiB-aligned frame available for new level-0 tables.
REQ-003 clock  in  1  single clock; all logic is on posedge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  map request present.
REQ-006 req_ready  out  1  block idle and able to accept a request.
REQ-007 req_vaddr  in  32  virtual address to map; bits [11:0] are ignored.
REQ-008 req_ppn  in  22  target physical page number.
REQ-009 req_perm  in  3  {X,W,R} leaf permissions.
REQ-010 req_user  in  1  leaf U bit.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 status  out  2  0 OK, 1 ALREADY_MAPPED, 2 SUPERPAGE, 3 BAD_PERM_OR_OOM; held from the done pulse until the next accept.
REQ-013 mem_address  out  32  memory byte address.
REQ-014 mem_data  out  32  write data.
REQ-015 mem_byteena  out  4  byte enables; constant 4'hF.
REQ-016 mem_wren  out  1  write enable.
REQ-017 mem_q  in  32  read data, valid in the cycle after the read address is driven with mem_wren=0.

Function
REQ-018 The block SHALL write Sv32 PTEs that the existing walker consumes: V=bit0, R=1, W=2, X=3, U=4, G=5, A=6, D=7, PPN=[31:10].
REQ-019 A request SHALL be accepted only on req_valid&&req_ready; the inputs are captured on that cycle; req_ready SHALL be 1 only in IDLE.
REQ-020 The states SHALL be IDLE, RD_L1, CHK_L1, ZERO, WR_L1, RD_L0, CHK_L0, WR_L0, DONE.
REQ-021 On accept with req_perm W=1 and R=0 or perm==0, the block SHALL go directly to DONE with status 3 and make no memory access.
REQ-022 RD_L1: mem_address=ROOT_BASE+{20'b0,vpn1,2'b00}, mem_wren=0; next state CHK_L1.
REQ-023 CHK_L1: the block SHALL sample mem_q; V=1 with any of R/W/X set -> DONE, status 2; V=1 pointer -> RD_L0; V=0 -> allocate.
REQ-024 Allocate: if alloc_ptr==0 (wrapped) -> DONE, status 3; otherwise frame=alloc_ptr, alloc_ptr+=32'h1000, next state ZERO.
REQ-025 ZERO: 1024 consecutive write cycles, mem_address=frame+4*i for i=0..1023, mem_data=0; then WR_L1.
REQ-026 WR_L1: one write cycle to the L1 address, mem_data={frame[31:12],10'h001}; then WR_L0. The pointer SHALL be written only after zeroing completes.
REQ-027 RD_L0: mem_address={pte.PPN[19:0],12'b0}+{20'b0,vpn0,2'b00}, truncated to 32 bits; CHK_L0 samples mem_q; V=1 -> DONE, status 1; else WR_L0.
REQ-028 WR_L0: one write cycle to the L0 address with mem_data={req_ppn,2'b00,D=1,A=1,G=0,U=req_user,X,W,R,V=1}; then DONE, status 0. For a freshly allocated table, the L0 address SHALL use frame as the base.
REQ-029 DONE: done=1 for exactly one cycle; the next state is IDLE.
REQ-030 Latency from the accept cycle to the done pulse SHALL be: existing pointer, empty slot: 6 cycles; fresh table: 1029 cycles; perm reject: 1 cycle.
REQ-031 mem_wren SHALL be 1 only in ZERO, WR_L1 and WR_L0; in all other states mem_address holds its last value and mem_wren=0.
REQ-032 alloc_ptr SHALL persist across requests and advance only on a successful allocation.

Reset
REQ-033 While reset=1 the block SHALL hold state IDLE, req_ready=0, done=0, status=0, mem_wren=0, mem_address=0, mem_data=0, alloc_ptr=FREE_BASE.
REQ-034 Reset asserted mid-operation, including during ZERO, SHALL abort at the next edge with no further writes; L1 is left unmodified because the pointer has not yet been written.
REQ-035 req_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-036 Zeroed memory, req vaddr=32'h0040_3000, ppn=22'h12345, perm=3'b011, user=0 -> 1024 zero writes 0x10000..0x10FFC, then [0x14]=32'h0000_4001, then [0x1000C]=32'h048D_14C7, status 0, done at accept+1029.
REQ-037 Repeat the same vaddr -> reads 0x14 and 0x1000C, no writes, status 1, done at accept+5.
REQ-038 vaddr=32'h0040_4000 after REQ-036 -> single write [0x10010], alloc_ptr unchanged at 0x11000, status 0, done at accept+6.
REQ-039 [0x18]=32'h0000_000F (leaf), vaddr=32'h0080_0000 -> status 2, no writes.
REQ-040 perm=3'b010 -> status 3, no memory access, done at accept+1.
REQ-041 Reset pulsed at ZERO i=100 -> mem_wren=0 next cycle, [0x14] still 0, req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/pt_mapper.sv
// Sv32 page-table mapper: installs one 4 KiB leaf PTE per request,
// allocating and zeroing a fresh level-0 table when the L1 slot is empty.
module pt_mapper #(
   parameter logic [31:0] ROOT_BASE = 32'h0000_0010,
   parameter logic [31:0] FREE_BASE = 32'h0001_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_vaddr,
   input  logic [21:0] req_ppn,
   input  logic [2:0]  req_perm,
   input  logic        req_user,
   output logic        done,
   output logic [1:0]  status,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data,
   output logic [3:0]  mem_byteena,
   output logic        mem_wren,
   input  logic [31:0] mem_q
);

   typedef enum logic [3:0] {
      IDLE, RD_L1, CHK_L1, ZERO, WR_L1, RD_L0, CHK_L0, WR_L0, DONE
   } state_t;

   localparam logic [1:0] ST_OK    = 2'd0;
   localparam logic [1:0] ST_MAPPED = 2'd1;
   localparam logic [1:0] ST_SUPER = 2'd2;
   localparam logic [1:0] ST_BAD   = 2'd3;

   state_t      state;
   logic [19:0] vpn;
   logic [21:0] ppn;
   logic [2:0]  perm;
   logic        user;
   logic [31:0] frame;
   logic [31:0] alloc_ptr;
   logic [31:0] l1_addr;
   logic [9:0]  cnt;

   logic [31:0] l1_calc;
   logic [31:0] l0_ptr_addr;
   logic [31:0] l0_new_addr;
   logic [31:0] leaf_pte;
   logic        bad_perm;
   logic        pte_v;
   logic        pte_leaf;
   logic        unused_bits;

   assign mem_byteena = 4'hF;

   assign l1_calc     = ROOT_BASE + {20'b0, req_vaddr[31:22], 2'b00};
   assign l0_ptr_addr = {mem_q[29:10], 12'b0} + {20'b0, vpn[9:0], 2'b00};
   assign l0_new_addr = frame + {20'b0, vpn[9:0], 2'b00};
   // D=1, A=1, G=0, then U, {X,W,R}, V=1
   assign leaf_pte    = {ppn, 2'b00, 1'b1, 1'b1, 1'b0, user, perm, 1'b1};
   assign bad_perm    = (req_perm[1] & ~req_perm[0]) | (req_perm == 3'b000);
   assign pte_v       = mem_q[0];
   assign pte_leaf    = |mem_q[3:1];
   assign unused_bits = ^{req_vaddr[11:0], mem_q[31:30], mem_q[9:4]};

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         req_ready   <= 1'b0;
         done        <= 1'b0;
         status      <= ST_OK;
         mem_wren    <= 1'b0;
         mem_address <= 32'h0;
         mem_data    <= 32'h0;
         alloc_ptr   <= FREE_BASE;
         frame       <= 32'h0;
         l1_addr     <= 32'h0;
         vpn         <= 20'h0;
         ppn         <= 22'h0;
         perm        <= 3'b0;
         user        <= 1'b0;
         cnt         <= 10'h0;
      end else begin
         done     <= 1'b0;
         mem_wren <= 1'b0;
         unique case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  vpn       <= req_vaddr[31:12];
                  ppn       <= req_ppn;
                  perm      <= req_perm;
                  user      <= req_user;
                  status    <= ST_OK;
                  if (bad_perm) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     status <= ST_BAD;
                  end else begin
                     state       <= RD_L1;
                     mem_address <= l1_calc;
                     l1_addr     <= l1_calc;
                  end
               end
            end
            RD_L1: state <= CHK_L1;
            CHK_L1: begin
               if (pte_v && pte_leaf) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  status <= ST_SUPER;
               end else if (pte_v) begin
                  state       <= RD_L0;
                  mem_address <= l0_ptr_addr;
               end else if (alloc_ptr == 32'h0) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  status <= ST_BAD;
               end else begin
                  state       <= ZERO;
                  frame       <= alloc_ptr;
                  alloc_ptr   <= alloc_ptr + 32'h1000;
                  mem_address <= alloc_ptr;
                  mem_data    <= 32'h0;
                  mem_wren    <= 1'b1;
                  cnt         <= 10'h0;
               end
            end
            ZERO: begin
               mem_wren <= 1'b1;
               if (cnt == 10'd1023) begin
                  // table is fully cleared; only now link it from L1
                  state       <= WR_L1;
                  mem_address <= l1_addr;
                  mem_data    <= {frame[31:12], 10'h001};
               end else begin
                  cnt         <= cnt + 10'd1;
                  mem_address <= mem_address + 32'd4;
               end
            end
            WR_L1: begin
               state       <= WR_L0;
               mem_address <= l0_new_addr;
               mem_data    <= leaf_pte;
               mem_wren    <= 1'b1;
            end
            RD_L0: state <= CHK_L0;
            CHK_L0: begin
               if (pte_v) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  status <= ST_MAPPED;
               end else begin
                  state    <= WR_L0;
                  mem_data <= leaf_pte;
                  mem_wren <= 1'b1;
               end
            end
            WR_L0: begin
               state  <= DONE;
               done   <= 1'b1;
               status <= ST_OK;
            end
            DONE: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pt_mapper.sv
// Directed bench for pt_mapper with a sparse memory model
// that logs every write for later inspection.
module tb_pt_mapper;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_vaddr = 32'h0;
   logic [21:0] req_ppn = 22'h0;
   logic [2:0]  req_perm = 3'b0;
   logic        req_user = 1'b0;
   logic        done;
   logic [1:0]  status;
   logic [31:0] mem_address;
   logic [31:0] mem_data;
   logic [3:0]  mem_byteena;
   logic        mem_wren;
   logic [31:0] mem_q = 32'h0;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] wa [$];
   logic [31:0] wd [$];

   pt_mapper dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_vaddr(req_vaddr), .req_ppn(req_ppn),
      .req_perm(req_perm), .req_user(req_user),
      .done(done), .status(status),
      .mem_address(mem_address), .mem_data(mem_data),
      .mem_byteena(mem_byteena), .mem_wren(mem_wren),
      .mem_q(mem_q)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      if (mem_wren) begin
         mem[mem_address] = mem_data;
         wa.push_back(mem_address);
         wd.push_back(mem_data);
      end
      mem_q <= mem.exists(mem_address) ? mem[mem_address] : 32'h0;
   end

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   task automatic run_req(input logic [31:0] va, input logic [21:0] pp,
                          input logic [2:0] pm, input logic u,
                          output int lat, output logic [1:0] st);
      int n;
      int acc;
      bit found;
      lat = -1;
      st = 2'b0;
      wa.delete();
      wd.delete();
      @(negedge clock);
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) begin
         tests++; fails++;
         $display("FAIL ready_wait: req_ready=0 required 1");
         return;
      end
      req_vaddr = va; req_ppn = pp; req_perm = pm; req_user = u;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      acc = cyc - 1;
      req_valid = 1'b0;
      found = 0;
      n = 0;
      while (n < 2000 && !found) begin
         @(negedge clock);
         if (done) found = 1;
         else n++;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL done_timeout: no done pulse within 2000 cycles");
         return;
      end
      lat = cyc - acc;
      st = status;
      @(negedge clock);
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL done_width: done=%0b required 0", done);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clock);
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %0b required 0", req_ready); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b required 0", done); end
      tests++; if (status !== 2'd0) begin fails++; $display("FAIL rst_status: got %0d required 0", status); end
      tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL rst_wren: got %0b required 0", mem_wren); end
      tests++; if (mem_address !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h required 0", mem_address); end
      tests++; if (mem_data !== 32'h0) begin fails++; $display("FAIL rst_data: got %h required 0", mem_data); end
      tests++; if (mem_byteena !== 4'hF) begin fails++; $display("FAIL byteena: got %h required f", mem_byteena); end
      reset = 1'b0;
      @(negedge clock);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %0b required 1", req_ready); end
   endtask

   task automatic test_abort;
      int n;
      int nw;
      wa.delete();
      wd.delete();
      @(negedge clock);
      req_vaddr = 32'h0040_3000; req_ppn = 22'h12345;
      req_perm = 3'b011; req_user = 1'b0;
      req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      n = 0;
      while (wa.size() < 100 && n < 300) begin
         @(negedge clock);
         n++;
      end
      tests++;
      if (wa.size() != 100 || mem_address !== 32'h0001_0190 || mem_wren !== 1'b1) begin
         fails++;
         $display("FAIL abort_zero_i100: writes=%0d addr=%h wren=%0b required 100 00010190 1",
                  wa.size(), mem_address, mem_wren);
      end
      reset = 1'b1;
      @(negedge clock);
      tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL abort_wren: got %0b required 0", mem_wren); end
      tests++; if (mem_address !== 32'h0) begin fails++; $display("FAIL abort_addr: got %h required 0", mem_address); end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %0b required 1", req_ready); end
      nw = wa.size();
      tests++; if (nw != 101) begin fails++; $display("FAIL abort_writes: got %0d required 101", nw); end
      tests++; if (rd(32'h14) !== 32'h0) begin fails++; $display("FAIL abort_l1: got %h required 0", rd(32'h14)); end
   endtask

   task automatic test_fresh;
      int lat;
      logic [1:0] st;
      int bad;
      run_req(32'h0040_3000, 22'h12345, 3'b011, 1'b0, lat, st);
      tests++; if (lat != 1029) begin fails++; $display("FAIL fresh_lat: got %0d required 1029", lat); end
      tests++; if (st !== 2'd0) begin fails++; $display("FAIL fresh_status: got %0d required 0", st); end
      tests++;
      if (wa.size() != 1026) begin
         fails++;
         $display("FAIL fresh_writes: got %0d required 1026", wa.size());
      end else begin
         bad = 0;
         for (int i = 0; i < 1024; i++)
            if (wa[i] !== 32'h0001_0000 + 32'(4 * i) || wd[i] !== 32'h0) bad++;
         tests++; if (bad != 0) begin fails++; $display("FAIL fresh_zero: %0d bad writes required 0", bad); end
         tests++;
         if (wa[1024] !== 32'h14 || wd[1024] !== 32'h0000_4001) begin
            fails++;
            $display("FAIL fresh_l1: got [%h]=%h required [00000014]=00004001", wa[1024], wd[1024]);
         end
         tests++;
         if (wa[1025] !== 32'h0001_000C || wd[1025] !== 32'h048D_14C7) begin
            fails++;
            $display("FAIL fresh_l0: got [%h]=%h required [0001000c]=048d14c7", wa[1025], wd[1025]);
         end
      end
   endtask

   task automatic test_already;
      int lat;
      logic [1:0] st;
      run_req(32'h0040_3000, 22'h12345, 3'b011, 1'b0, lat, st);
      tests++; if (lat != 5) begin fails++; $display("FAIL mapped_lat: got %0d required 5", lat); end
      tests++; if (st !== 2'd1) begin fails++; $display("FAIL mapped_status: got %0d required 1", st); end
      tests++; if (wa.size() != 0) begin fails++; $display("FAIL mapped_writes: got %0d required 0", wa.size()); end
      repeat (3) @(negedge clock);
      tests++; if (status !== 2'd1) begin fails++; $display("FAIL status_hold: got %0d required 1", status); end
   endtask

   task automatic test_existing_ptr;
      int lat;
      logic [1:0] st;
      run_req(32'h0040_4000, 22'h00ABC, 3'b101, 1'b1, lat, st);
      tests++; if (lat != 6) begin fails++; $display("FAIL ptr_lat: got %0d required 6", lat); end
      tests++; if (st !== 2'd0) begin fails++; $display("FAIL ptr_status: got %0d required 0", st); end
      tests++;
      if (wa.size() != 1 || wa[0] !== 32'h0001_0010 || wd[0] !== 32'h002A_F0DB) begin
         fails++;
         $display("FAIL ptr_write: n=%0d got [%h]=%h required 1 [00010010]=002af0db",
                  wa.size(), wa.size() > 0 ? wa[0] : 32'h0, wd.size() > 0 ? wd[0] : 32'h0);
      end
   endtask

   task automatic test_fresh_second;
      int lat;
      logic [1:0] st;
      run_req(32'h00C0_0000, 22'h3FFFFF, 3'b111, 1'b1, lat, st);
      tests++; if (lat != 1029) begin fails++; $display("FAIL fresh2_lat: got %0d required 1029", lat); end
      tests++;
      if (wa.size() != 1026) begin
         fails++;
         $display("FAIL fresh2_writes: got %0d required 1026", wa.size());
      end else begin
         tests++; if (wa[0] !== 32'h0001_1000) begin fails++; $display("FAIL fresh2_frame: got %h required 00011000", wa[0]); end
         tests++;
         if (wa[1024] !== 32'h1C || wd[1024] !== 32'h0000_4401) begin
            fails++;
            $display("FAIL fresh2_l1: got [%h]=%h required [0000001c]=00004401", wa[1024], wd[1024]);
         end
         tests++;
         if (wa[1025] !== 32'h0001_1000 || wd[1025] !== 32'hFFFF_FCDF) begin
            fails++;
            $display("FAIL fresh2_l0: got [%h]=%h required [00011000]=fffffcdf", wa[1025], wd[1025]);
         end
      end
   endtask

   task automatic test_superpage;
      int lat;
      logic [1:0] st;
      mem[32'h18] = 32'h0000_000F;
      run_req(32'h0080_0000, 22'h00001, 3'b001, 1'b0, lat, st);
      tests++; if (st !== 2'd2) begin fails++; $display("FAIL super_status: got %0d required 2", st); end
      tests++; if (lat != 3) begin fails++; $display("FAIL super_lat: got %0d required 3", lat); end
      tests++; if (wa.size() != 0) begin fails++; $display("FAIL super_writes: got %0d required 0", wa.size()); end
   endtask

   task automatic test_perm;
      int lat;
      logic [1:0] st;
      logic [31:0] a0;
      a0 = mem_address;
      run_req(32'h0100_0000, 22'h00002, 3'b010, 1'b0, lat, st);
      tests++; if (st !== 2'd3) begin fails++; $display("FAIL perm_w_status: got %0d required 3", st); end
      tests++; if (lat != 1) begin fails++; $display("FAIL perm_w_lat: got %0d required 1", lat); end
      tests++; if (wa.size() != 0) begin fails++; $display("FAIL perm_w_writes: got %0d required 0", wa.size()); end
      tests++; if (mem_address !== a0) begin fails++; $display("FAIL perm_w_addr: got %h required %h", mem_address, a0); end
      run_req(32'h0100_0000, 22'h00002, 3'b000, 1'b0, lat, st);
      tests++; if (st !== 2'd3 || lat != 1) begin fails++; $display("FAIL perm_zero: status=%0d lat=%0d required 3 1", st, lat); end
      repeat (3) @(negedge clock);
      tests++; if (status !== 2'd3) begin fails++; $display("FAIL perm_hold: got %0d required 3", status); end
   endtask

   initial begin
      test_reset();
      test_abort();
      test_fresh();
      test_already();
      test_existing_ptr();
      test_fresh_second();
      test_superpage();
      test_perm();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
